button_event: RTL and testbench

- Sits directly downstream of the button debouncer.
- Consumes the debounced, clean button level and classifies user gestures into single-cycle event pulses: press, release, short press, double click and long press, plus optional auto-repeat while held.
- Its outputs drive the processor's front-panel/control logic as synchronous strobes, one clock wide.

---
 rtl/button_event.sv | 106 ++++++++++
 tb/tb_button_event.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// button_event: classifies a debounced button level into press/release/short/double/long strobes.
// Define BUTTON_EVENT_AUTOREPEAT_EN to emit repeat_pulse every RPT_CYC cycles while a long press is held.
module button_event #(
  parameter int CNT_W    = 25,
  parameter int LONG_CYC = 19_000_000,
  parameter int DBL_CYC  = 9_500_000,
  parameter int RPT_CYC  = 3_800_000
) (
  input  logic clk,
  input  logic reset,
  input  logic db_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
  localparam int LD_MAX  = LONG_CYC > DBL_CYC ? LONG_CYC : DBL_CYC;
  localparam int MAX_CYC = LD_MAX > RPT_CYC ? LD_MAX : RPT_CYC;
  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_END  = CNT_W'(DBL_CYC - 1);
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_END  = CNT_W'(RPT_CYC - 1);
`endif
  if ((64'd1 << CNT_W) <= 64'(MAX_CYC)) begin : g_bad_cnt_w
    $error("button_event: CNT_W too narrow for the configured periods");
  end
  state_t state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic db_q, rise, fall, short_n, dbl_n, long_n, rpt_n;
  assign rise = db_in & ~db_q;
  assign fall = ~db_in & db_q;
  always_comb begin
    state_n = state;
    timer_n = timer;
    short_n = 1'b0;
    dbl_n   = 1'b0;
    long_n  = 1'b0;
    rpt_n   = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n = PRESS1;
        timer_n = '0;
      end
      // A fall on the very cycle the hold matures still counts as long; the release then ends the gesture.
      PRESS1: if (timer == LONG_END && db_q) begin
        long_n  = 1'b1;
        state_n = fall ? IDLE : LONG;
        timer_n = '0;
      end else if (fall) begin
        state_n = WAIT2;
        timer_n = '0;
      end else timer_n = timer + 1'b1;
      WAIT2: if (rise) begin
        state_n = PRESS2;
        timer_n = '0;
      end else if (timer == DBL_END) begin
        short_n = 1'b1;
        state_n = IDLE;
        timer_n = '0;
      end else timer_n = timer + 1'b1;
      PRESS2: if (fall) begin
        dbl_n   = 1'b1;
        state_n = IDLE;
      end
      LONG: begin
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
        rpt_n   = timer == RPT_END;
        timer_n = rpt_n ? '0 : timer + 1'b1;
`endif
        if (fall) begin
          state_n = IDLE;
          timer_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      db_q          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      db_q          <= db_in;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_press   <= short_n;
      double_click  <= dbl_n;
      long_press    <= long_n;
      repeat_pulse  <= rpt_n;
      busy          <= state_n != IDLE;
    end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: gesture-level reference model feeding an event scoreboard for button_event.
module tb_button_event;
  localparam int LONG = 20, DBL = 10, RPT = 5;
  localparam logic [5:0] P = 6'd1, R = 6'd2, SP = 6'd4, DC = 6'd8, LP = 6'd16, RP = 6'd32;
  logic clk = 1'b0, reset = 1'b1, db_in = 1'b0;
  logic press_pulse, release_pulse, short_press, double_click, long_press, repeat_pulse, busy;
  typedef struct {int t; logic [5:0] m;} ev_t;
  ev_t exp_q[$];
  bit s[$];
  logic [5:0] em[];
  bit be[];
  int errors = 0, checks = 0, cyc = -1;
  bit mon_on = 1'b0;
  logic [5:0] got;
  ev_t e;

  button_event #(.CNT_W(8), .LONG_CYC(LONG), .DBL_CYC(DBL), .RPT_CYC(RPT)) dut (
    .clk(clk), .reset(reset), .db_in(db_in),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .short_press(short_press),
    .double_click(double_click), .long_press(long_press), .repeat_pulse(repeat_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {busy, repeat_pulse, long_press, double_click, short_press, release_pulse, press_pulse};
  endfunction

  task automatic chk(input string name, input logic [6:0] g, input logic [6:0] w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, g, w);
    end
  endtask

  task automatic seg(input bit l, input int n);
    for (int i = 0; i < n; i++) s.push_back(l);
  endtask

  // first index >= from where the level changes to lvl (level before sample 0 is low)
  function automatic int nxt(input int from, input bit lvl);
    for (int j = from; j < s.size(); j++)
      if (s[j] == lvl && (j == 0 ? 1'b0 : s[j-1]) != lvl) return j;
    return -1;
  endfunction

  task automatic mark_busy(input int a, input int b);
    for (int k = a; k < b && k < s.size(); k++) be[k] = 1'b1;
  endtask

  task automatic build_model();
    int n, i, r1, f1, r2, f2;
    n = s.size();
    em = new[n];
    be = new[n];
    for (int k = 0; k < n; k++) begin
      em[k] = '0;
      be[k] = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      if (nxt(k, 1'b1) == k) em[k] |= P;
      if (nxt(k, 1'b0) == k) em[k] |= R;
    end
    i = 0;
    while (1) begin
      r1 = nxt(i, 1'b1);
      if (r1 < 0) break;
      f1 = nxt(r1 + 1, 1'b0);
      if (f1 < 0) f1 = n;
      if (f1 - r1 >= LONG) begin
        if (r1 + LONG < n) em[r1+LONG] |= LP;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
        for (int t = r1 + LONG + RPT; t <= f1 && t < n; t += RPT) em[t] |= RP;
`endif
        mark_busy(r1, f1);
        i = f1;
      end else begin
        r2 = nxt(f1 + 1, 1'b1);
        if (r2 >= 0 && r2 <= f1 + DBL) begin
          f2 = nxt(r2 + 1, 1'b0);
          if (f2 < 0) f2 = n;
          if (f2 < n) em[f2] |= DC;
          mark_busy(r1, f2);
          i = f2;
        end else begin
          if (f1 + DBL < n) em[f1+DBL] |= SP;
          mark_busy(r1, f1 + DBL);
          i = f1 + DBL + 1;
        end
      end
    end
    for (int k = 0; k < n; k++)
      if (em[k] != 0) exp_q.push_back('{t: k, m: em[k]});
  endtask

  always @(posedge clk) if (mon_on) begin
    #1;
    cyc++;
    got = outs();
    checks++;
    if (busy !== be[cyc]) begin
      errors++;
      $display("FAIL busy: cycle %0d got %b required %b", cyc, busy, be[cyc]);
    end
    if (got != 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: cycle %0d got mask %b, required no event", cyc, got);
      end else begin
        e = exp_q.pop_front();
        if (e.t != cyc || e.m !== got) begin
          errors++;
          $display("FAIL event: got cycle %0d mask %b, required cycle %0d mask %b", cyc, got, e.t, e.m);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset_idle", outs(), 7'b0);
    @(negedge clk);
    reset = 1'b0;
    db_in = 1'b1;
    @(posedge clk);
    #1 chk("first_press", outs(), 7'b1000001);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset", outs(), 7'b0);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", outs(), 7'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("press_after_reset", outs(), 7'b1000001);
    @(posedge clk);
    #1 chk("press_single", outs(), 7'b1000000);
    @(negedge clk);
    reset = 1'b1;
    db_in = 1'b0;
    seg(0, 3); seg(1, 5); seg(0, 12);
    seg(1, 3); seg(0, 4); seg(1, 3); seg(0, 15);
    seg(1, 40); seg(0, 15);
    seg(1, 3); seg(0, 10); seg(1, 3); seg(0, 15);
    seg(1, 19); seg(0, 15);
    seg(1, 20); seg(0, 15);
    seg(1, 30); seg(0, 15);
    for (int g = 0; g < 120; g++) begin
      seg(1, $urandom_range(1, 35));
      seg(0, $urandom_range(1, 14));
    end
    seg(0, 30);
    build_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    db_in = s[0];
    mon_on = 1'b1;
    for (int k = 1; k < s.size(); k++) begin
      @(negedge clk);
      db_in = s[k];
    end
    @(posedge clk);
    #3 mon_on = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d left over, required 0 (next at cycle %0d)", exp_q.size(), exp_q[0].t);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
